// File: rtl/host_uart_frame_assembler_if.sv
// Byte-stream-in / frame-out bundle between the UART receiver, the frame assembler and the command decoder.
// The master side is the assembler; the slave side is the receiver/decoder environment.
interface host_uart_frame_assembler_if;
    logic [7:0]    rx_data;
    logic          rx_valid;
    logic          rx_error;
    logic          dec_done;
    logic [1023:0] frame_data;
    logic          frame_start;
    logic [7:0]    frame_len;
    logic          busy;
    logic          err_length;
    logic          err_framing;
    logic          err_timeout;
    logic          err_overrun;

    modport master (
        input  rx_data, rx_valid, rx_error, dec_done,
        output frame_data, frame_start, frame_len, busy,
               err_length, err_framing, err_timeout, err_overrun
    );

    modport slave (
        output rx_data, rx_valid, rx_error, dec_done,
        input  frame_data, frame_start, frame_len, busy,
               err_length, err_framing, err_timeout, err_overrun
    );
endinterface

// File: rtl/host_uart_frame_assembler.sv
// Packs length-prefixed UART byte frames into a 1024-bit word and hands each complete frame
// to the command decoder over a start/done level handshake, flagging malformed input.
module host_uart_frame_assembler #(
    parameter int MAX_BYTES      = 128,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int TIMEOUT_W      = 20
) (
    input logic clk,
    input logic reset,
    host_uart_frame_assembler_if.master bus
);

    typedef enum logic [2:0] {IDLE, PAYLOAD, ISSUE, WAIT_ACK, WAIT_DONE} state_t;

    localparam logic [7:0]           MAX_LEN  = 8'(MAX_BYTES);
    localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    state_t               state;
    logic [7:0]           idx;
    logic [TIMEOUT_W-1:0] tcnt;
    logic [1023:0]        frame_data;
    logic [7:0]           frame_len;
    logic                 frame_start;
    logic                 busy;
    logic                 err_length;
    logic                 err_framing;
    logic                 err_timeout;
    logic                 err_overrun;

    assign bus.frame_data  = frame_data;
    assign bus.frame_len   = frame_len;
    assign bus.frame_start = frame_start;
    assign bus.busy        = busy;
    assign bus.err_length  = err_length;
    assign bus.err_framing = err_framing;
    assign bus.err_timeout = err_timeout;
    assign bus.err_overrun = err_overrun;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= '0;
            tcnt        <= '0;
            frame_data  <= '0;
            frame_len   <= '0;
            frame_start <= 1'b0;
            busy        <= 1'b0;
            err_length  <= 1'b0;
            err_framing <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;
        end else begin
            err_length  <= 1'b0;
            err_framing <= 1'b0;
            err_timeout <= 1'b0;
            err_overrun <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.rx_error) begin
                        err_framing <= 1'b1;
                    end else if (bus.rx_valid) begin
                        if (bus.rx_data == 8'd0 || bus.rx_data > MAX_LEN) begin
                            err_length <= 1'b1;
                        end else begin
                            frame_len  <= bus.rx_data;
                            frame_data <= '0;
                            idx        <= '0;
                            tcnt       <= '0;
                            busy       <= 1'b1;
                            state      <= PAYLOAD;
                        end
                    end
                end

                PAYLOAD: begin
                    // rx_error outranks a coincident rx_valid: the byte is suspect, drop the frame.
                    if (bus.rx_error || (!bus.rx_valid && tcnt == TMO_LAST)) begin
                        err_framing <= bus.rx_error;
                        err_timeout <= !bus.rx_error;
                        frame_data  <= '0;
                        frame_len   <= '0;
                        idx         <= '0;
                        tcnt        <= '0;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end else if (bus.rx_valid) begin
                        frame_data[{idx[6:0], 3'b000} +: 8] <= bus.rx_data;
                        tcnt <= '0;
                        if (idx == frame_len - 8'd1) begin
                            state <= ISSUE;
                        end else begin
                            idx <= idx + 8'd1;
                        end
                    end else begin
                        tcnt <= tcnt + TIMEOUT_W'(1);
                    end
                end

                ISSUE, WAIT_ACK, WAIT_DONE: begin
                    // The frame is frozen here; stray input is reported but never stored.
                    if (bus.rx_error) begin
                        err_framing <= 1'b1;
                    end else if (bus.rx_valid) begin
                        err_overrun <= 1'b1;
                    end

                    if (state == ISSUE) begin
                        if (bus.dec_done) begin
                            frame_start <= 1'b1;
                            state       <= WAIT_ACK;
                        end
                    end else if (state == WAIT_ACK) begin
                        if (!bus.dec_done) begin
                            frame_start <= 1'b0;
                            state       <= WAIT_DONE;
                        end
                    end else if (bus.dec_done) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end

                default: begin
                    frame_start <= 1'b0;
                    busy        <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_host_uart_frame_assembler.sv
// Directed bench for host_uart_frame_assembler: stimulus pushes expected events into a queue,
// an independent negedge monitor pops and compares whenever the DUT pulses an error or raises frame_start.
module tb_host_uart_frame_assembler;

    localparam int TMO = 40;

    typedef enum int {EV_LEN, EV_FRM, EV_TMO, EV_OVR, EV_START} ev_kind_t;
    typedef struct {
        ev_kind_t      kind;
        logic [7:0]    len;
        logic [1023:0] data;
    } ev_t;

    logic clk;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    ev_t  exp_q[$];
    logic prev_start;
    logic [1023:0] exp1;
    logic [1023:0] exp_big;

    host_uart_frame_assembler_if bus ();

    host_uart_frame_assembler #(
        .MAX_BYTES(128),
        .TIMEOUT_CYCLES(TMO),
        .TIMEOUT_W(6)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic push_ev(input ev_kind_t k, input logic [7:0] len, input logic [1023:0] data);
        ev_t e;
        e.kind = k;
        e.len  = len;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic expect_ev(input ev_kind_t k);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_event got=%0d want=none", int'(k));
        end else begin
            e = exp_q.pop_front();
            check("event_kind", int'(k), int'(e.kind));
            if (k == EV_START) begin
                check("start_frame_len", bus.frame_len, e.len);
                check("start_frame_data", bus.frame_data, e.data);
            end
        end
    endtask

    // Monitor: decoupled from stimulus, reacts to every observable event.
    always @(negedge clk) begin
        if (reset) begin
            prev_start = 1'b0;
        end else begin
            if (bus.err_length)  expect_ev(EV_LEN);
            if (bus.err_framing) expect_ev(EV_FRM);
            if (bus.err_timeout) expect_ev(EV_TMO);
            if (bus.err_overrun) expect_ev(EV_OVR);
            if (bus.frame_start && !prev_start) expect_ev(EV_START);
            prev_start = bus.frame_start;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        tick(1);
        bus.rx_valid = 1'b0;
    endtask

    task automatic handshake();
        bus.dec_done = 1'b0;
        tick(1);
        bus.dec_done = 1'b1;
        tick(1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_frame_data"}, bus.frame_data, '0);
        check({tag, "_frame_len"}, bus.frame_len, 0);
        check({tag, "_frame_start"}, bus.frame_start, 0);
        check({tag, "_busy"}, bus.busy, 0);
        check({tag, "_errs"}, {bus.err_length, bus.err_framing, bus.err_timeout, bus.err_overrun}, 0);
    endtask

    initial begin
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        bus.rx_error = 1'b0;
        bus.dec_done = 1'b1;
        reset        = 1'b1;
        tick(2);
        check_all_zero("reset");
        reset = 1'b0;
        tick(1);

        // Three-byte frame, decoder idle.
        exp1 = '0;
        exp1[23:0] = 24'hBBAA03;
        push_ev(EV_START, 8'd3, exp1);
        send(8'h03);
        check("busy_in_payload", bus.busy, 1);
        send(8'h03);
        send(8'hAA);
        send(8'hBB);
        check("start_low_at_last_byte", bus.frame_start, 0);
        tick(1);
        check("start_high_1clk_later", bus.frame_start, 1);
        check("frame_len_3", bus.frame_len, 3);
        check("frame_data_3", bus.frame_data, exp1);
        bus.dec_done = 1'b0;
        tick(1);
        check("start_drops_on_ack", bus.frame_start, 0);
        check("busy_wait_done", bus.busy, 1);
        bus.dec_done = 1'b1;
        tick(1);
        check("busy_after_done", bus.busy, 0);
        check("frame_retained", bus.frame_data, exp1);

        // Bad length bytes.
        push_ev(EV_LEN, 8'd0, '0);
        send(8'h00);
        push_ev(EV_LEN, 8'd0, '0);
        send(8'h81);
        tick(1);
        check("busy_after_badlen", bus.busy, 0);
        check("start_after_badlen", bus.frame_start, 0);

        // Inter-byte timeout, then a one-byte frame.
        send(8'h05);
        send(8'h21);
        send(8'h22);
        push_ev(EV_TMO, 8'd0, '0);
        tick(TMO - 1);
        check("busy_before_timeout", bus.busy, 1);
        tick(1);
        check("busy_after_timeout", bus.busy, 0);
        check("data_cleared_timeout", bus.frame_data, '0);
        check("len_cleared_timeout", bus.frame_len, 0);
        exp1 = '0;
        exp1[7:0] = 8'h5A;
        push_ev(EV_START, 8'd1, exp1);
        send(8'h01);
        send(8'h5A);
        tick(1);
        check("start_len1", bus.frame_start, 1);
        handshake();
        check("busy_len1_done", bus.busy, 0);

        // rx_valid and rx_error together in PAYLOAD.
        send(8'h04);
        send(8'h11);
        push_ev(EV_FRM, 8'd0, '0);
        bus.rx_error = 1'b1;
        send(8'h99);
        bus.rx_error = 1'b0;
        check("busy_after_framing", bus.busy, 0);
        check("data_after_framing", bus.frame_data, '0);
        check("len_after_framing", bus.frame_len, 0);

        // Full 128-byte frame, decoder busy at completion.
        exp_big = '0;
        for (int i = 0; i < 128; i++) exp_big[8*i +: 8] = 8'(i);
        bus.dec_done = 1'b0;
        push_ev(EV_START, 8'd128, exp_big);
        send(8'd128);
        for (int i = 0; i < 128; i++) send(8'(i));
        for (int i = 0; i < 3; i++) begin
            tick(1);
            check("start_held_low", bus.frame_start, 0);
        end
        check("busy_in_issue", bus.busy, 1);
        bus.dec_done = 1'b1;
        tick(1);
        check("start_after_dec_idle", bus.frame_start, 1);
        check("top_byte", bus.frame_data[1023:1016], 8'h7F);
        check("bottom_byte", bus.frame_data[7:0], 8'h00);

        // Overrun during WAIT_ACK.
        push_ev(EV_OVR, 8'd0, '0);
        send(8'hE1);
        push_ev(EV_OVR, 8'd0, '0);
        send(8'hE2);
        tick(1);
        check("data_after_overrun", bus.frame_data, exp_big);
        check("start_after_overrun", bus.frame_start, 1);
        handshake();
        check("busy_big_done", bus.busy, 0);

        // Asynchronous reset in the middle of a payload.
        send(8'h04);
        send(8'h33);
        #2 reset = 1'b1;
        #1 check_all_zero("midreset");
        tick(1);
        reset = 1'b0;
        tick(2);
        check("queue_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
